clock_failover_ctrl: RTL and testbench
======================================

// Module: clock_failover_ctrl
// PURPOSE
//   Downstream consumer of the clock quality monitor. Qualifies the 10 MHz
//   SiT5503 reference once per measurement strobe and decides whether the PPS
//   and timing path disciplines to it, holds over, or free-runs. Drives the
//   reference-select and alarm outputs used by the PPS generator and status
//   registers.
// PARAMETERS
//   LOCK_COUNT    4      consecutive good evaluations required to (re)lock
//   LOSS_COUNT    2      consecutive bad evaluations required to leave LOCKED
//   HOLDOVER_MAX  3600   evaluations allowed in HOLDOVER before FREERUN
//   DEV_LIMIT     50     max acceptable ref_freq_deviation (ppm, unsigned)
// PORTS
//   clk_sys             in   1   system clock, 100 MHz
//   rst_n               in   1   asynchronous reset, active low
//   enable              in   1   controller enable; low forces IDLE
//   meas_strobe         in   1   1-cycle pulse: monitor outputs updated
//   ref_clock_valid     in   1   reference within monitor tolerance
//   ref_freq_deviation  in   16  reference deviation, ppm
//   sys_clock_valid     in   1   system clock within monitor tolerance
//   clocks_synchronized in   1   sys/ref phase relation stable
//   use_ref_clock       out  1   1 = discipline to reference
//   holdover_active     out  1   1 in HOLDOVER
//   ctrl_state          out  3   current FSM state encoding
//   ref_alarm           out  1   1 in FREERUN or FAULT
//   switch_count        out  8   transitions into/out of LOCKED, saturating
//   holdover_time       out  16  evaluations spent in current HOLDOVER
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, internal counters 0.
//   Evaluation occurs only in cycles with meas_strobe=1; otherwise all state
//   and counters hold. Registered outputs update in the cycle after the strobe.
//   ref_good = ref_clock_valid & clocks_synchronized &
//              (ref_freq_deviation <= DEV_LIMIT), unsigned compare.
//   good_cnt: +1 on ref_good strobe, cleared on bad strobe; sat at LOCK_COUNT.
//   bad_cnt : mirror of good_cnt on !ref_good; sat at LOSS_COUNT.
//   Thresholds compare against the count including the current strobe.
//   States (enc): IDLE=0 ACQUIRE=1 LOCKED=2 HOLDOVER=3 FREERUN=4 FAULT=5.
//   - IDLE: enable=1 -> ACQUIRE (next cycle, no strobe needed).
//   - ACQUIRE: good_cnt reaches LOCK_COUNT -> LOCKED.
//   - LOCKED: use_ref_clock=1; bad_cnt reaches LOSS_COUNT -> HOLDOVER.
//   - HOLDOVER: holdover_time cleared on entry, +1 per strobe (sat 0xFFFF);
//     good_cnt reaches LOCK_COUNT -> LOCKED; else holdover_time reaches
//     HOLDOVER_MAX -> FREERUN. Relock wins if both on same strobe.
//   - FREERUN: ref_alarm=1; good_cnt reaches LOCK_COUNT -> LOCKED.
//   - FAULT: ref_alarm=1, use_ref_clock=0; LOCK_COUNT consecutive strobes with
//     sys_clock_valid=1 -> ACQUIRE (good/bad counters cleared on exit).
//   - Any non-IDLE state: strobe with sys_clock_valid=0 -> FAULT; has priority
//     over every other transition on that strobe.
//   enable=0: synchronous return to IDLE next cycle, counters/holdover_time
//     cleared, switch_count retained. enable=0 beats sys fault.
//   switch_count +1 on every entry to or exit from LOCKED; holds at 255.
//   holdover_time holds its last value after leaving HOLDOVER until next entry.
//   Async reset mid-operation: immediate return to reset values.
// STRUCTURE
//   clock_mon_pkg: state encoding constants, ctrl_state width, DEV unit notes;
//   shared with clock_monitor and status register block.
//   One sub-module: strobe_debounce (saturating consecutive-event counter with
//   threshold flag); instantiated for good, bad and sys-recovery counts.
// TESTING
//   1 enable, 4 good strobes -> LOCKED after 4th strobe, use_ref=1, switch=1.
//   2 LOCKED, 1 bad strobe then good -> stays LOCKED; 2 bad -> HOLDOVER,
//     holdover_active=1, use_ref=0, switch=2.
//   3 HOLDOVER_MAX=5 override, 5 bad strobes -> FREERUN, ref_alarm=1,
//     holdover_time=5; then 4 good -> LOCKED.
//   4 ref_freq_deviation=50 -> good, 51 -> bad; deviation 0xFFFF no wrap.
//   5 sys_clock_valid=0 on strobe while LOCKED with ref bad -> FAULT (not
//     HOLDOVER); 4 valid strobes -> ACQUIRE.
//   6 enable drop in HOLDOVER -> IDLE, counters 0; 300 LOCKED toggles ->
//     switch_count=255; rst_n pulse mid-ACQUIRE -> all outputs 0.

Source files
------------

// File: rtl/clock_mon_pkg.sv
// Purpose: shared definitions for the clock monitor, failover controller and
//          status register block (state encoding, bus widths, unit notes).
// Contents:
//   CTRL_STATE_W  width of the exported controller state
//   DEV_W         width of ref_freq_deviation; unit is ppm, unsigned
//   SWITCH_W      width of the saturating LOCKED entry/exit counter
//   HOLD_W        width of the holdover evaluation counter
//   ctrl_state_e  controller state encoding (visible in status registers)
package clock_mon_pkg;

    localparam int unsigned CTRL_STATE_W = 3;
    localparam int unsigned DEV_W        = 16;  // ppm, unsigned magnitude
    localparam int unsigned SWITCH_W     = 8;
    localparam int unsigned HOLD_W       = 16;

    typedef enum logic [CTRL_STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_ACQUIRE  = 3'd1,
        ST_LOCKED   = 3'd2,
        ST_HOLDOVER = 3'd3,
        ST_FREERUN  = 3'd4,
        ST_FAULT    = 3'd5
    } ctrl_state_e;

    // States in which the reference cannot be trusted at all.
    function automatic logic is_alarm_state(input ctrl_state_e s);
        return (s == ST_FREERUN) || (s == ST_FAULT);
    endfunction

endpackage

// File: rtl/clock_failover_ctrl_strobe_debounce.sv
// Purpose: saturating counter of consecutive qualified events, advanced only
//          on measurement strobes; flags when the threshold is reached.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   clear       synchronous clear (wins over counting)
//   strobe      evaluation pulse
//   event_in    event observed on this strobe (0 restarts the run)
//   hit_c       combinational: this strobe brings the run to THRESH
module strobe_debounce #(
    parameter int unsigned THRESH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic strobe,
    input  logic event_in,
    output logic hit_c
);

    localparam int unsigned CNT_W = $clog2(THRESH + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Threshold includes the event on the current strobe.
    assign hit_c = strobe && event_in && ((32'(count_q) + 32'd1) >= THRESH);

    // Saturating run-length update.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (strobe) begin
            if (!event_in) begin
                count_d = '0;
            end else if (32'(count_q) < THRESH) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/clock_failover_ctrl.sv
// Purpose: qualifies the 10 MHz reference once per measurement strobe and
//          selects discipline / holdover / free-run for the PPS path.
// Ports:
//   clk_sys, rst_n       100 MHz system clock, async active-low reset
//   enable               low forces IDLE and clears run counters
//   meas_strobe          one-cycle pulse: monitor inputs are fresh
//   ref_clock_valid, ref_freq_deviation, sys_clock_valid, clocks_synchronized
//                        monitor status
//   use_ref_clock        discipline to reference (LOCKED)
//   holdover_active      in HOLDOVER
//   ctrl_state           current state encoding
//   ref_alarm            in FREERUN or FAULT
//   switch_count         saturating count of LOCKED entries/exits
//   holdover_time        evaluations spent in the current/last HOLDOVER
module clock_failover_ctrl
    import clock_mon_pkg::*;
#(
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned LOSS_COUNT   = 2,
    parameter int unsigned HOLDOVER_MAX = 3600,
    parameter int unsigned DEV_LIMIT    = 50
) (
    input  logic                    clk_sys,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    meas_strobe,
    input  logic                    ref_clock_valid,
    input  logic [DEV_W-1:0]        ref_freq_deviation,
    input  logic                    sys_clock_valid,
    input  logic                    clocks_synchronized,
    output logic                    use_ref_clock,
    output logic                    holdover_active,
    output logic [CTRL_STATE_W-1:0] ctrl_state,
    output logic                    ref_alarm,
    output logic [SWITCH_W-1:0]     switch_count,
    output logic [HOLD_W-1:0]       holdover_time
);

    ctrl_state_e                state_q, state_d;
    logic                       use_ref_clock_q, use_ref_clock_d;
    logic                       holdover_active_q, holdover_active_d;
    logic                       ref_alarm_q, ref_alarm_d;
    logic [CTRL_STATE_W-1:0]    ctrl_state_q, ctrl_state_d;
    logic [SWITCH_W-1:0]        switch_count_q, switch_count_d;
    logic [HOLD_W-1:0]          holdover_time_q, holdover_time_d;

    logic eval_c;
    logic ref_good_c;
    logic good_hit_c, bad_hit_c, sys_hit_c, hold_hit_c;
    logic run_clear_c, sys_clear_c;

    // A strobe only counts once the controller is active.
    assign eval_c     = meas_strobe && enable && (state_q != ST_IDLE);
    assign ref_good_c = ref_clock_valid && clocks_synchronized &&
                        (32'(ref_freq_deviation) <= DEV_LIMIT);
    assign hold_hit_c = eval_c && (state_q == ST_HOLDOVER) &&
                        ((32'(holdover_time_q) + 32'd1) >= HOLDOVER_MAX);

    // Good/bad runs restart when disabled and when recovering out of FAULT.
    assign run_clear_c = !enable || (state_q == ST_IDLE) ||
                         ((state_q == ST_FAULT) && (state_d != ST_FAULT));
    // Recovery run only exists while sitting in FAULT.
    assign sys_clear_c = (state_q != ST_FAULT) || (state_d != ST_FAULT);

    strobe_debounce #(.THRESH(LOCK_COUNT)) u_good_deb (
        .clk      (clk_sys),
        .rst_n    (rst_n),
        .clear    (run_clear_c),
        .strobe   (eval_c),
        .event_in (ref_good_c),
        .hit_c    (good_hit_c)
    );

    strobe_debounce #(.THRESH(LOSS_COUNT)) u_bad_deb (
        .clk      (clk_sys),
        .rst_n    (rst_n),
        .clear    (run_clear_c),
        .strobe   (eval_c),
        .event_in (!ref_good_c),
        .hit_c    (bad_hit_c)
    );

    strobe_debounce #(.THRESH(LOCK_COUNT)) u_sys_deb (
        .clk      (clk_sys),
        .rst_n    (rst_n),
        .clear    (sys_clear_c),
        .strobe   (eval_c && (state_q == ST_FAULT)),
        .event_in (sys_clock_valid),
        .hit_c    (sys_hit_c)
    );

    // State and output registers.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            use_ref_clock_q   <= 1'b0;
            holdover_active_q <= 1'b0;
            ref_alarm_q       <= 1'b0;
            ctrl_state_q      <= '0;
            switch_count_q    <= '0;
            holdover_time_q   <= '0;
        end else begin
            state_q           <= state_d;
            use_ref_clock_q   <= use_ref_clock_d;
            holdover_active_q <= holdover_active_d;
            ref_alarm_q       <= ref_alarm_d;
            ctrl_state_q      <= ctrl_state_d;
            switch_count_q    <= switch_count_d;
            holdover_time_q   <= holdover_time_d;
        end
    end

    // Next state: disable beats system-clock fault, which beats everything else.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_ACQUIRE;
        end else if (eval_c) begin
            if (!sys_clock_valid) begin
                state_d = ST_FAULT;
            end else begin
                case (state_q)
                    ST_ACQUIRE:  if (good_hit_c) state_d = ST_LOCKED;
                    ST_LOCKED:   if (bad_hit_c)  state_d = ST_HOLDOVER;
                    ST_HOLDOVER: begin
                        // Relock takes precedence over holdover expiry.
                        if (good_hit_c)      state_d = ST_LOCKED;
                        else if (hold_hit_c) state_d = ST_FREERUN;
                    end
                    ST_FREERUN:  if (good_hit_c) state_d = ST_LOCKED;
                    ST_FAULT:    if (sys_hit_c)  state_d = ST_ACQUIRE;
                    default:     state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Registered outputs follow the state being entered.
    always_comb begin
        use_ref_clock_d   = (state_d == ST_LOCKED);
        holdover_active_d = (state_d == ST_HOLDOVER);
        ref_alarm_d       = is_alarm_state(state_d);
        ctrl_state_d      = state_d;
        switch_count_d    = switch_count_q;
        holdover_time_d   = holdover_time_q;

        if (((state_d == ST_LOCKED) != (state_q == ST_LOCKED)) &&
            (switch_count_q != '1)) begin
            switch_count_d = switch_count_q + SWITCH_W'(1);
        end

        if (!enable) begin
            holdover_time_d = '0;
        end else if ((state_d == ST_HOLDOVER) && (state_q != ST_HOLDOVER)) begin
            holdover_time_d = '0;
        end else if (eval_c && (state_q == ST_HOLDOVER) && (holdover_time_q != '1)) begin
            holdover_time_d = holdover_time_q + HOLD_W'(1);
        end
    end

    assign use_ref_clock   = use_ref_clock_q;
    assign holdover_active = holdover_active_q;
    assign ref_alarm       = ref_alarm_q;
    assign ctrl_state      = ctrl_state_q;
    assign switch_count    = switch_count_q;
    assign holdover_time   = holdover_time_q;

endmodule

// File: tb/tb_clock_failover_ctrl.sv
// Purpose: self-checking bench for clock_failover_ctrl; directed scenarios
//          plus randomized traffic against a behavioural reference model.
module tb_clock_failover_ctrl;

    localparam int LOCK = 4;
    localparam int LOSS = 2;
    localparam int HMAX = 5;
    localparam int DLIM = 50;

    localparam int S_IDLE = 0, S_ACQ = 1, S_LOCKED = 2, S_HOLD = 3,
                   S_FREE = 4, S_FAULT = 5;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        meas_strobe;
    logic        ref_clock_valid;
    logic [15:0] ref_freq_deviation;
    logic        sys_clock_valid;
    logic        clocks_synchronized;
    logic        use_ref_clock;
    logic        holdover_active;
    logic [2:0]  ctrl_state;
    logic        ref_alarm;
    logic [7:0]  switch_count;
    logic [15:0] holdover_time;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    int m_state, m_good, m_bad, m_sys, m_hot, m_sw;

    always #5 clk_sys = ~clk_sys;

    clock_failover_ctrl #(
        .LOCK_COUNT   (LOCK),
        .LOSS_COUNT   (LOSS),
        .HOLDOVER_MAX (HMAX),
        .DEV_LIMIT    (DLIM)
    ) dut (
        .clk_sys             (clk_sys),
        .rst_n               (rst_n),
        .enable              (enable),
        .meas_strobe         (meas_strobe),
        .ref_clock_valid     (ref_clock_valid),
        .ref_freq_deviation  (ref_freq_deviation),
        .sys_clock_valid     (sys_clock_valid),
        .clocks_synchronized (clocks_synchronized),
        .use_ref_clock       (use_ref_clock),
        .holdover_active     (holdover_active),
        .ctrl_state          (ctrl_state),
        .ref_alarm           (ref_alarm),
        .switch_count        (switch_count),
        .holdover_time       (holdover_time)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_good = 0; m_bad = 0; m_sys = 0; m_hot = 0; m_sw = 0;
    endtask

    function automatic int sat_inc(input int v, input int lim);
        return (v < lim) ? v + 1 : v;
    endfunction

    // One clock of the behavioural model, from the current input values.
    task automatic model_step();
        int  nxt;
        bit  good;
        if (!enable) begin
            if (m_state == S_LOCKED) m_sw = sat_inc(m_sw, 255);
            m_state = S_IDLE; m_good = 0; m_bad = 0; m_sys = 0; m_hot = 0;
            return;
        end
        if (m_state == S_IDLE) begin
            m_state = S_ACQ;
            return;
        end
        if (!meas_strobe) return;

        good = ref_clock_valid && clocks_synchronized && (int'(ref_freq_deviation) <= DLIM);
        if (good) begin m_good = sat_inc(m_good, LOCK); m_bad = 0; end
        else      begin m_bad  = sat_inc(m_bad, LOSS);  m_good = 0; end
        if (m_state == S_FAULT) m_sys = sys_clock_valid ? sat_inc(m_sys, LOCK) : 0;
        if (m_state == S_HOLD)  m_hot = sat_inc(m_hot, 65535);

        nxt = m_state;
        if (!sys_clock_valid) nxt = S_FAULT;
        else if (m_state == S_ACQ    && m_good >= LOCK) nxt = S_LOCKED;
        else if (m_state == S_LOCKED && m_bad  >= LOSS) nxt = S_HOLD;
        else if (m_state == S_HOLD) begin
            if (m_good >= LOCK)     nxt = S_LOCKED;
            else if (m_hot >= HMAX) nxt = S_FREE;
        end
        else if (m_state == S_FREE  && m_good >= LOCK) nxt = S_LOCKED;
        else if (m_state == S_FAULT && m_sys  >= LOCK) begin
            nxt = S_ACQ; m_good = 0; m_bad = 0;
        end

        if (nxt != S_FAULT) m_sys = 0;
        if (nxt == S_HOLD && m_state != S_HOLD) m_hot = 0;
        if ((nxt == S_LOCKED) != (m_state == S_LOCKED)) m_sw = sat_inc(m_sw, 255);
        m_state = nxt;
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, "/state"},    32'(ctrl_state),      32'(m_state));
        check_eq({tag, "/use_ref"},  32'(use_ref_clock),   32'(m_state == S_LOCKED));
        check_eq({tag, "/holdover"}, 32'(holdover_active), 32'(m_state == S_HOLD));
        check_eq({tag, "/alarm"},    32'(ref_alarm),       32'(m_state == S_FREE || m_state == S_FAULT));
        check_eq({tag, "/switch"},   32'(switch_count),    32'(m_sw));
        check_eq({tag, "/hold_t"},   32'(holdover_time),   32'(m_hot));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "/state"},    32'(ctrl_state),      32'd0);
        check_eq({tag, "/use_ref"},  32'(use_ref_clock),   32'd0);
        check_eq({tag, "/holdover"}, 32'(holdover_active), 32'd0);
        check_eq({tag, "/alarm"},    32'(ref_alarm),       32'd0);
        check_eq({tag, "/switch"},   32'(switch_count),    32'd0);
        check_eq({tag, "/hold_t"},   32'(holdover_time),   32'd0);
    endtask

    // Advance one clock; inputs were set before the edge, outputs sampled 1ns after.
    task automatic step();
        @(posedge clk_sys);
        model_step();
        #1;
        meas_strobe = 1'b0;
    endtask

    task automatic strobe(input bit rv, input int dev, input bit sv, input bit cs);
        ref_clock_valid     = rv;
        ref_freq_deviation  = 16'(dev);
        sys_clock_valid     = sv;
        clocks_synchronized = cs;
        meas_strobe         = 1'b1;
        step();
    endtask

    task automatic good_n(input int n);
        for (int i = 0; i < n; i++) strobe(1'b1, 10, 1'b1, 1'b1);
    endtask

    task automatic bad_n(input int n);
        for (int i = 0; i < n; i++) strobe(1'b0, 10, 1'b1, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; meas_strobe = 1'b0; ref_clock_valid = 1'b0;
        ref_freq_deviation = '0; sys_clock_valid = 1'b1; clocks_synchronized = 1'b1;
        model_reset();
        repeat (2) @(posedge clk_sys);
        #1;
        check_all_zero("reset");
        @(negedge clk_sys);
        rst_n = 1'b1;

        // 1: acquire and lock
        enable = 1'b1;
        step();
        check_eq("t1_acquire", 32'(ctrl_state), S_ACQ);
        good_n(3);
        check_eq("t1_not_yet", 32'(ctrl_state), S_ACQ);
        good_n(1);
        check_eq("t1_locked",  32'(ctrl_state),    S_LOCKED);
        check_eq("t1_use_ref", 32'(use_ref_clock), 1);
        check_eq("t1_switch",  32'(switch_count),  1);
        check_model("t1");

        // 2: single bad tolerated, two consecutive bad -> holdover
        bad_n(1); good_n(1);
        check_eq("t2_stay_locked", 32'(ctrl_state), S_LOCKED);
        bad_n(2);
        check_eq("t2_holdover", 32'(holdover_active), 1);
        check_eq("t2_use_ref",  32'(use_ref_clock),   0);
        check_eq("t2_switch",   32'(switch_count),    2);
        check_model("t2");

        // 3: holdover expiry and relock from free-run
        bad_n(4);
        check_eq("t3_hold_t4", 32'(holdover_time), 4);
        check_eq("t3_still_hold", 32'(ctrl_state), S_HOLD);
        bad_n(1);
        check_eq("t3_freerun", 32'(ctrl_state),    S_FREE);
        check_eq("t3_alarm",   32'(ref_alarm),     1);
        check_eq("t3_hold_t5", 32'(holdover_time), 5);
        good_n(4);
        check_eq("t3_relock",  32'(ctrl_state),    S_LOCKED);
        check_eq("t3_switch",  32'(switch_count),  3);
        check_model("t3");

        // 4: deviation boundary, no wrap at 0xFFFF
        strobe(1'b1, 51, 1'b1, 1'b1); strobe(1'b1, 51, 1'b1, 1'b1);
        check_eq("t4_dev51_bad", 32'(ctrl_state), S_HOLD);
        for (int i = 0; i < 4; i++) strobe(1'b1, 50, 1'b1, 1'b1);
        check_eq("t4_dev50_good", 32'(ctrl_state), S_LOCKED);
        strobe(1'b1, 65535, 1'b1, 1'b1); strobe(1'b1, 65535, 1'b1, 1'b1);
        check_eq("t4_devffff_bad", 32'(ctrl_state), S_HOLD);
        good_n(4);
        check_model("t4");

        // 5: sys fault beats loss-of-lock, then recovery to ACQUIRE
        bad_n(1);
        strobe(1'b0, 10, 1'b0, 1'b1);
        check_eq("t5_fault",   32'(ctrl_state),    S_FAULT);
        check_eq("t5_alarm",   32'(ref_alarm),     1);
        check_eq("t5_use_ref", 32'(use_ref_clock), 0);
        good_n(3);
        check_eq("t5_still_fault", 32'(ctrl_state), S_FAULT);
        good_n(1);
        check_eq("t5_acquire", 32'(ctrl_state), S_ACQ);
        good_n(4);
        check_model("t5");

        // 6: enable drop clears runs and holdover time
        bad_n(2); good_n(3);
        enable = 1'b0;
        step();
        check_eq("t6_idle",   32'(ctrl_state),    S_IDLE);
        check_eq("t6_hold_t", 32'(holdover_time), 0);
        check_eq("t6_switch", 32'(switch_count),  10);
        enable = 1'b1;
        step();
        good_n(1);
        check_eq("t6_runs_cleared", 32'(ctrl_state), S_ACQ);
        good_n(3);
        for (int i = 0; i < 150; i++) begin
            bad_n(2); good_n(4);
        end
        check_eq("t6_switch_sat", 32'(switch_count), 255);
        check_model("t6");

        // 6b: async reset mid-ACQUIRE
        enable = 1'b0; step();
        enable = 1'b1; step();
        good_n(2);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk_sys);
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            int r;
            enable              = ($urandom_range(0, 199) != 0);
            meas_strobe         = ($urandom_range(0, 2) == 0);
            ref_clock_valid     = ($urandom_range(0, 9) != 0);
            clocks_synchronized = ($urandom_range(0, 19) != 0);
            sys_clock_valid     = ($urandom_range(0, 29) != 0);
            r = int'($urandom_range(0, 3));
            if (r == 0)      ref_freq_deviation = 16'($urandom_range(45, 55));
            else if (r == 1) ref_freq_deviation = 16'($urandom);
            else             ref_freq_deviation = 16'($urandom_range(0, 50));
            step();
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
